// File: rtl/outport_vc_alloc_if.sv
// rtl/outport_vc_alloc_if.sv - requester/link handshake bundle for the output-port VC allocator
//
// Purpose: groups the per-requester request/flit signals, the grant and
// forward outputs, the link select and the per-VC credit signals.
// Ports (signals):
//   req       NP*VCN  req[i*VCN+v]: requester i asks for output VC v
//   flit_v    NP      requester i has a flit ready
//   flit_tail NP      requester i's current flit is a tail
//   gnt       NP*VCN  requester i owns output VC v
//   fwd       NP      requester i's flit is taken this cycle
//   link_v    1       a flit is driven onto the link
//   sel_vc    VCN     one-hot VC of the link flit
//   crd_ret   VCN     credit return pulse per VC
//   crd       VCN*CW  credit count per VC
//   crd_err   VCN     sticky credit error (only with OUTPORT_VC_ALLOC_CRD_CHK_EN)
// Modports: master = requesters/downstream side, slave = allocator.
interface outport_vc_alloc_if #(
    parameter int NP  = 4,
    parameter int VCN = 2,
    parameter int CRD = 4
);
    localparam int CW = $clog2(CRD + 1);

    logic [NP*VCN-1:0] req;
    logic [NP-1:0]     flit_v;
    logic [NP-1:0]     flit_tail;
    logic [NP*VCN-1:0] gnt;
    logic [NP-1:0]     fwd;
    logic              link_v;
    logic [VCN-1:0]    sel_vc;
    logic [VCN-1:0]    crd_ret;
    logic [VCN*CW-1:0] crd;
`ifdef OUTPORT_VC_ALLOC_CRD_CHK_EN
    logic [VCN-1:0]    crd_err;

    modport master (
        output req, flit_v, flit_tail, crd_ret,
        input  gnt, fwd, link_v, sel_vc, crd, crd_err
    );
    modport slave (
        input  req, flit_v, flit_tail, crd_ret,
        output gnt, fwd, link_v, sel_vc, crd, crd_err
    );
`else
    modport master (
        output req, flit_v, flit_tail, crd_ret,
        input  gnt, fwd, link_v, sel_vc, crd
    );
    modport slave (
        input  req, flit_v, flit_tail, crd_ret,
        output gnt, fwd, link_v, sel_vc, crd
    );
`endif
endinterface

// File: rtl/outport_vc_alloc.sv
// rtl/outport_vc_alloc.sv - output-port VC allocator with wormhole lock and credit-gated link scheduler
//
// Purpose: each output VC is granted round-robin to one input-port requester
// and held until that requester's tail flit is sent. Each cycle one flit from
// the granted VCs with a ready flit and a nonzero credit count is placed on the
// shared link, chosen round-robin across VCs.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    outport_vc_alloc_if.slave (req, flit_v, flit_tail, crd_ret in;
//          gnt, fwd, link_v, sel_vc, crd [, crd_err] out)
// Optional build macro: OUTPORT_VC_ALLOC_CRD_CHK_EN adds the sticky crd_err
// output flagging credit overflow and sends attempted at zero credit.
module outport_vc_alloc #(
    parameter int NP  = 4,
    parameter int VCN = 2,
    parameter int CRD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    outport_vc_alloc_if.slave bus
);
    localparam int CW = $clog2(CRD + 1);
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int VW = (VCN > 1) ? $clog2(VCN) : 1;
    localparam logic [CW-1:0] CRD_INIT = CW'(CRD);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} vc_state_e;

    vc_state_e     state_q [VCN];
    vc_state_e     state_d [VCN];
    logic [PW-1:0] owner_q [VCN];
    logic [PW-1:0] owner_d [VCN];
    logic [PW-1:0] ptr_q   [VCN];
    logic [PW-1:0] ptr_d   [VCN];
    logic [VW-1:0] lptr_q;
    logic [VW-1:0] lptr_d;
    logic [CW-1:0] crd_q   [VCN];
    logic [CW-1:0] crd_d   [VCN];

    logic [NP-1:0]  owns;
    logic [VW-1:0]  low_vc [NP];
    logic [NP-1:0]  cand   [VCN];
    logic [VCN-1:0] elig;
    logic [VCN-1:0] send;

    // Request decode: a requester competes only for its lowest requested VC,
    // and not at all while it already owns one. This also guarantees that two
    // idle VCs never pick the same requester in the same cycle.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            low_vc[i] = '0;
            for (int v = VCN - 1; v >= 0; v--) begin
                if (bus.req[i*VCN+v]) low_vc[i] = VW'(v);
            end
        end
        for (int v = 0; v < VCN; v++) begin
            cand[v] = '0;
            for (int i = 0; i < NP; i++) begin
                cand[v][i] = bus.req[i*VCN+v] && (low_vc[i] == VW'(v)) && !owns[i];
            end
        end
    end

    // Link scheduler: combinational from registered VC state and credits.
    always_comb begin
        logic found;
        int   idx;
        found      = 1'b0;
        idx        = 0;
        elig       = '0;
        send       = '0;
        lptr_d     = lptr_q;
        bus.fwd    = '0;
        for (int v = 0; v < VCN; v++) begin
            elig[v] = (state_q[v] == BUSY) && bus.flit_v[owner_q[v]] && (crd_q[v] != '0);
        end
        for (int k = 1; k <= VCN; k++) begin
            idx = (int'(lptr_q) + k) % VCN;
            if (!found && elig[idx]) begin
                found     = 1'b1;
                send[idx] = 1'b1;
                lptr_d    = VW'(idx);
            end
        end
        for (int v = 0; v < VCN; v++) begin
            if (send[v]) bus.fwd[owner_q[v]] = 1'b1;
        end
        bus.link_v = |send;
        bus.sel_vc = send;
    end

    // VC FSM next state: IDLE arbitrates, BUSY holds until the owner's tail leaves.
    always_comb begin
        logic found;
        int   idx;
        for (int v = 0; v < VCN; v++) begin
            state_d[v] = state_q[v];
            owner_d[v] = owner_q[v];
            ptr_d[v]   = ptr_q[v];
            found      = 1'b0;
            idx        = 0;
            case (state_q[v])
                IDLE: begin
                    for (int k = 1; k <= NP; k++) begin
                        idx = (int'(ptr_q[v]) + k) % NP;
                        if (!found && cand[v][idx]) begin
                            found      = 1'b1;
                            state_d[v] = BUSY;
                            owner_d[v] = PW'(idx);
                            ptr_d[v]   = PW'(idx);
                        end
                    end
                end
                BUSY: begin
                    if (send[v] && bus.flit_tail[owner_q[v]]) state_d[v] = IDLE;
                end
                default: state_d[v] = IDLE;
            endcase
        end
    end

    // VC FSM outputs: grants and the ownership mask are decoded from registers only.
    always_comb begin
        bus.gnt = '0;
        owns    = '0;
        for (int v = 0; v < VCN; v++) begin
            for (int i = 0; i < NP; i++) begin
                if ((state_q[v] == BUSY) && (owner_q[v] == PW'(i))) begin
                    bus.gnt[i*VCN+v] = 1'b1;
                    owns[i]          = 1'b1;
                end
            end
            bus.crd[v*CW +: CW] = crd_q[v];
        end
    end

    // Credit update: a send and a return in the same cycle cancel out.
    always_comb begin
        for (int v = 0; v < VCN; v++) begin
            crd_d[v] = crd_q[v];
            if (send[v] && !bus.crd_ret[v]) begin
                crd_d[v] = crd_q[v] - 1'b1;
            end else if (!send[v] && bus.crd_ret[v] && (crd_q[v] != CRD_INIT)) begin
                crd_d[v] = crd_q[v] + 1'b1;
            end
        end
    end

    // VC FSM state register plus credit and link-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VCN; v++) begin
                state_q[v] <= IDLE;
                owner_q[v] <= '0;
                ptr_q[v]   <= PW'(NP - 1);
                crd_q[v]   <= CRD_INIT;
            end
            lptr_q <= VW'(VCN - 1);
        end else begin
            for (int v = 0; v < VCN; v++) begin
                state_q[v] <= state_d[v];
                owner_q[v] <= owner_d[v];
                ptr_q[v]   <= ptr_d[v];
                crd_q[v]   <= crd_d[v];
            end
            lptr_q <= lptr_d;
        end
    end

`ifdef OUTPORT_VC_ALLOC_CRD_CHK_EN
    // Sticky error: return at full credit (overflow) or a send at zero credit,
    // the latter excluded by the eligibility check and kept as a safety hook.
    logic [VCN-1:0] crd_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd_err_q <= '0;
        end else begin
            for (int v = 0; v < VCN; v++) begin
                if ((bus.crd_ret[v] && (crd_q[v] == CRD_INIT)) ||
                    (send[v] && (crd_q[v] == '0))) begin
                    crd_err_q[v] <= 1'b1;
                end
            end
        end
    end

    assign bus.crd_err = crd_err_q;
`endif
endmodule

// File: tb/tb_outport_vc_alloc.sv
// tb/tb_outport_vc_alloc.sv - directed self-checking bench for outport_vc_alloc
module tb_outport_vc_alloc;
    localparam int NP  = 4;
    localparam int VCN = 2;
    localparam int CRD = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    outport_vc_alloc_if #(.NP(NP), .VCN(VCN), .CRD(CRD)) bus ();

    outport_vc_alloc #(.NP(NP), .VCN(VCN), .CRD(CRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.flit_v    = '0;
        bus.flit_tail = '0;
        bus.crd_ret   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (bus.gnt !== 8'h00) begin $display("FAIL rst_gnt got=%h exp=%h", bus.gnt, 8'h00); bad++; end
        total++;
        if (bus.crd !== 6'o44) begin $display("FAIL rst_crd got=%o exp=%o", bus.crd, 6'o44); bad++; end
        total++;
        if (bus.link_v !== 1'b0) begin $display("FAIL rst_link_v got=%b exp=0", bus.link_v); bad++; end
        total++;
        if (bus.sel_vc !== 2'b00) begin $display("FAIL rst_sel_vc got=%b exp=00", bus.sel_vc); bad++; end
        total++;
        if (bus.fwd !== 4'b0000) begin $display("FAIL rst_fwd got=%b exp=0000", bus.fwd); bad++; end
        total++;
`ifdef OUTPORT_VC_ALLOC_CRD_CHK_EN
        if (bus.crd_err !== 2'b00) begin $display("FAIL rst_crd_err got=%b exp=00", bus.crd_err); bad++; end
        total++;
`endif
    endtask

    task automatic test_first_grant();
        do_reset();
        bus.req    = 8'h01;
        bus.flit_v = 4'b0001;
        #1;
        if (bus.gnt !== 8'h00) begin $display("FAIL fg_gnt_c0 got=%h exp=%h", bus.gnt, 8'h00); bad++; end
        total++;
        tick();
        #1;
        if (bus.gnt !== 8'h01) begin $display("FAIL fg_gnt_c1 got=%h exp=%h", bus.gnt, 8'h01); bad++; end
        total++;
        if (bus.link_v !== 1'b1 || bus.sel_vc !== 2'b01 || bus.fwd !== 4'b0001) begin
            $display("FAIL fg_link got=%b/%b/%b exp=1/01/0001", bus.link_v, bus.sel_vc, bus.fwd); bad++;
        end
        total++;
        tick();
        #1;
        if (bus.crd !== 6'o43) begin $display("FAIL fg_crd got=%o exp=%o", bus.crd, 6'o43); bad++; end
        total++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g [8];
        logic [3:0] exp_f [8];
        exp_g = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00, 8'h10, 8'h00, 8'h01};
        exp_f = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
        do_reset();
        bus.req       = 8'h15;
        bus.flit_v    = 4'b0111;
        bus.flit_tail = 4'b0111;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            #1;
            if (bus.gnt !== exp_g[c]) begin
                $display("FAIL rr_gnt_c%0d got=%h exp=%h", c, bus.gnt, exp_g[c]); bad++;
            end
            total++;
            if (bus.fwd !== exp_f[c]) begin
                $display("FAIL rr_fwd_c%0d got=%b exp=%b", c, bus.fwd, exp_f[c]); bad++;
            end
            total++;
        end
    endtask

    task automatic test_link_alternate();
        logic [1:0] exp_s [4];
        logic [3:0] exp_f [4];
        exp_s = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_f = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        bus.req    = 8'h09;
        bus.flit_v = 4'b0011;
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            if (bus.gnt !== 8'h09) begin $display("FAIL alt_gnt_c%0d got=%h exp=09", c + 1, bus.gnt); bad++; end
            total++;
            if (bus.sel_vc !== exp_s[c] || bus.fwd !== exp_f[c]) begin
                $display("FAIL alt_sel_c%0d got=%b/%b exp=%b/%b", c + 1, bus.sel_vc, bus.fwd, exp_s[c], exp_f[c]); bad++;
            end
            total++;
        end
        tick();
        #1;
        if (bus.crd !== 6'o22) begin $display("FAIL alt_crd got=%o exp=%o", bus.crd, 6'o22); bad++; end
        total++;
    endtask

    task automatic test_credit_stall();
        do_reset();
        bus.req    = 8'h01;
        bus.flit_v = 4'b0001;
        #1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            if (bus.fwd !== 4'b0001 || bus.crd[2:0] !== 3'(5 - k)) begin
                $display("FAIL cs_send%0d got=%b/%0d exp=0001/%0d", k, bus.fwd, bus.crd[2:0], 5 - k); bad++;
            end
            total++;
        end
        tick();
        #1;
        if (bus.fwd !== 4'b0000 || bus.link_v !== 1'b0 || bus.crd[2:0] !== 3'd0) begin
            $display("FAIL cs_stall got=%b/%b/%0d exp=0000/0/0", bus.fwd, bus.link_v, bus.crd[2:0]); bad++;
        end
        total++;
        if (bus.gnt !== 8'h01) begin $display("FAIL cs_lock got=%h exp=01", bus.gnt); bad++; end
        total++;
        tick();
        bus.crd_ret = 2'b01;
        #1;
        if (bus.fwd !== 4'b0000 || bus.gnt !== 8'h01) begin
            $display("FAIL cs_stall2 got=%b/%h exp=0000/01", bus.fwd, bus.gnt); bad++;
        end
        total++;
        tick();
        bus.crd_ret   = 2'b00;
        bus.req       = 8'h00;
        bus.flit_tail = 4'b0001;
        #1;
        if (bus.crd[2:0] !== 3'd1 || bus.fwd !== 4'b0001 || bus.link_v !== 1'b1) begin
            $display("FAIL cs_resume got=%0d/%b/%b exp=1/0001/1", bus.crd[2:0], bus.fwd, bus.link_v); bad++;
        end
        total++;
        tick();
        #1;
        if (bus.gnt !== 8'h00 || bus.crd[2:0] !== 3'd0) begin
            $display("FAIL cs_release got=%h/%0d exp=00/0", bus.gnt, bus.crd[2:0]); bad++;
        end
        total++;
    endtask

    task automatic test_credit_same_cycle();
        do_reset();
        bus.req    = 8'h01;
        bus.flit_v = 4'b0001;
        #1;
        tick();
        tick();
        tick();
        bus.crd_ret = 2'b01;
        #1;
        if (bus.crd[2:0] !== 3'd2 || bus.fwd !== 4'b0001) begin
            $display("FAIL sc_pre got=%0d/%b exp=2/0001", bus.crd[2:0], bus.fwd); bad++;
        end
        total++;
        tick();
        bus.flit_v = 4'b0000;
        #1;
        if (bus.crd[2:0] !== 3'd2) begin $display("FAIL sc_both got=%0d exp=2", bus.crd[2:0]); bad++; end
        total++;
        if (bus.link_v !== 1'b0) begin $display("FAIL sc_idle_link got=%b exp=0", bus.link_v); bad++; end
        total++;
        tick();
        #1;
        if (bus.crd[2:0] !== 3'd3) begin $display("FAIL sc_ret3 got=%0d exp=3", bus.crd[2:0]); bad++; end
        total++;
        tick();
        #1;
        if (bus.crd[2:0] !== 3'd4) begin $display("FAIL sc_ret4 got=%0d exp=4", bus.crd[2:0]); bad++; end
        total++;
`ifdef OUTPORT_VC_ALLOC_CRD_CHK_EN
        if (bus.crd_err !== 2'b00) begin $display("FAIL sc_err_pre got=%b exp=00", bus.crd_err); bad++; end
        total++;
`endif
        tick();
        bus.crd_ret = 2'b00;
        #1;
        if (bus.crd[2:0] !== 3'd4) begin $display("FAIL sc_sat got=%0d exp=4", bus.crd[2:0]); bad++; end
        total++;
`ifdef OUTPORT_VC_ALLOC_CRD_CHK_EN
        if (bus.crd_err !== 2'b01) begin $display("FAIL sc_err got=%b exp=01", bus.crd_err); bad++; end
        total++;
`endif
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req    = 8'h08;
        bus.flit_v = 4'b0010;
        #1;
        tick();
        tick();
        #1;
        if (bus.gnt !== 8'h08 || bus.crd[5:3] !== 3'd3) begin
            $display("FAIL rm_pre got=%h/%0d exp=08/3", bus.gnt, bus.crd[5:3]); bad++;
        end
        total++;
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.gnt !== 8'h00 || bus.crd !== 6'o44) begin
            $display("FAIL rm_async got=%h/%o exp=00/44", bus.gnt, bus.crd); bad++;
        end
        total++;
        if (bus.link_v !== 1'b0 || bus.fwd !== 4'b0000) begin
            $display("FAIL rm_link got=%b/%b exp=0/0000", bus.link_v, bus.fwd); bad++;
        end
        total++;
        bus.req    = 8'h05;
        bus.flit_v = 4'b0011;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        if (bus.gnt !== 8'h00) begin $display("FAIL rm_post got=%h exp=00", bus.gnt); bad++; end
        total++;
        tick();
        #1;
        if (bus.gnt !== 8'h01) begin $display("FAIL rm_first got=%h exp=01", bus.gnt); bad++; end
        total++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_link_alternate();
        test_credit_stall();
        test_credit_same_cycle();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/outport_vc_alloc.md
Name: outport_vc_alloc

Overview:
- Clocked output-port controller for the SDM router.
- Allocates each output VC to one of NP competing input-port requesters, which are driven from the per-VC routing requests.
- Holds each allocation (wormhole lock) until the tail flit is sent.
- Each cycle, schedules one flit from the allocated VCs onto the shared physical link, gated by per-VC downstream credits.

Parameters:
- NP, 4, number of requesters (input ports) competing for this output port
- VCN, 2, number of output VCs
- CRD, 4, downstream buffer depth per VC (initial credits); credit width CW = $clog2(CRD+1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NP*VCN  req[i*VCN+v]: requester i's head flit asks for output VC v
- flit_v  input  NP  requester i has a flit ready
- flit_tail  input  NP  requester i's current flit is a tail
- gnt  output  NP*VCN  registered; gnt[i*VCN+v] = requester i owns output VC v
- fwd  output  NP  one-hot or zero; requester i's flit is taken this cycle
- link_v  output  1  a flit is driven onto the link this cycle
- sel_vc  output  VCN  one-hot VC of the flit on the link; zero when link_v=0
- crd_ret  input  VCN  one-cycle credit return pulse per VC from downstream
- crd  output  VCN*CW  current credit count per VC (registered)

Behaviour:
- Reset (async, rst_n=0):
  - every VC goes to IDLE and gnt=0.
  - crd[v]=CRD.
  - All round-robin pointers = NP-1 (VC pointers) or VCN-1 (link pointer), so index 0 has first priority.
  - fwd, link_v and sel_vc are 0 while reset is held.
  - Reset mid-packet drops all locks; no flit is forwarded in the reset cycle.
- Per-VC state machine, two states:
  - IDLE: if any req[i][v] is set by a requester not already owning a VC, pick i round-robin starting at ptr_v+1 mod NP. Then gnt[i][v]<=1, owner_v<=i, ptr_v<=i, state<=BUSY.
  - BUSY: hold owner. When owner's tail is forwarded on VC v in cycle t: state<=IDLE and gnt clears at t+1. Re-arbitration happens at t+1; the new gnt appears at t+2.
- Request latency: req at cycle t in IDLE -> gnt high at t+1. req is ignored while BUSY.
- A requester asserting multiple req bits has only its lowest-indexed v honoured.
- A requester owning some VC is masked from all other VC arbitrations.
- Link scheduling (combinational from registered state):
  - VC v is eligible when BUSY && flit_v[owner_v] && crd[v]>0.
  - Pick one eligible VC round-robin from lptr+1 mod VCN. Then link_v=1, sel_vc[v]=1, fwd[owner_v]=1, and lptr<=v at the clock edge.
  - No eligible VC: link_v=0, sel_vc=0, fwd=0, lptr unchanged.
- A requester may forward body flits without asserting req; only flit_v is consulted while BUSY.
- Credits:
  - send only: crd-1.
  - crd_ret only: crd+1.
  - Both in the same cycle: unchanged.
  - crd_ret when crd==CRD: saturate at CRD.
  - crd==0: VC is ineligible; the lock is held indefinitely.
- Single-flit packet (head=tail): grant at t+1, forward with tail at the earliest t+1, IDLE at t+2.
- A tail sent in the same cycle as a credit return follows both rules independently.

Optional Feature:
- Macro OUTPORT_VC_ALLOC_CRD_CHK_EN.
- Defined:
  - Adds output crd_err (VCN bits), reset 0.
  - crd_err[v] is sticky-set on crd_ret[v] when crd[v]==CRD (overflow).
  - crd_err[v] is also set if a send on v is computed while crd[v]==0; this is unreachable by design and serves as an assertion hook.
  - Cleared only by reset.
- Undefined: no crd_err port; overflow silently saturates.

Test Plan:
- Reset, then req[0*VCN+0]=1 at t0 -> gnt[0]=1 at t0+1. With flit_v[0]=1, fwd[0]=1, link_v=1, sel_vc=01, crd[0]: 4->3.
- Requesters 0, 1, 2 all request VC0 with 1-flit packets repeatedly -> grants in order 0, 1, 2, 0. Each grant is 2 cycles after the previous tail.
- Requester 0 owns VC0 and requester 1 owns VC1, both with flit_v=1 -> link alternates sel_vc 01, 10, 01, ..., with fwd toggling between 0 and 1.
- VC0 with 4-flit body, no crd_ret -> 4 flits sent and crd[0]=0. The 5th flit is stalled (fwd=0) until a crd_ret[0] pulse, then sent next cycle. The gnt lock is held throughout.
- crd_ret[0] and a send on VC0 in the same cycle at crd=2 -> crd stays 2. crd_ret[0] at crd=4 -> stays 4, and crd_err[0]=1 with CRD_CHK_EN.
- Assert rst_n=0 mid-packet with gnt[1*VCN+1]=1 -> gnt=0, crd=4, link_v=0 immediately. After release, requester 0 wins the first contention.
